// File: rtl/msm_pkg.sv
// Shared definitions for the MSM field-arithmetic blocks.
// Field width default, BN254 base modulus and modular-multiplier FSM states.
package msm_pkg;

    localparam int unsigned FIELD_W = 256;

    localparam logic [255:0] BN254_P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mod_mul_state_t;

endpackage

// File: rtl/mod_mul_step.sv
// One interleaved double-and-add step: acc_o = (2*acc + bit*a) mod p.
// Inputs must satisfy acc, a < p so one conditional subtract per stage suffices.
module mod_mul_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH:0] p_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] d;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] s;

    assign p_ext = {1'b0, p_i};
    assign dbl   = {acc_i, 1'b0};
    assign d     = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    assign sum   = bit_i ? (d + {1'b0, a_i}) : d;
    assign s     = (sum >= p_ext) ? (sum - p_ext) : sum;
    assign acc_o = s[WIDTH-1:0];

endmodule

// File: rtl/mod_mul_iter.sv
// Bit-serial modular multiplier, result = (a*b) mod modulus, MSB first.
// WIDTH step cycles plus one DONE cycle; operands latched on acceptance.
module mod_mul_iter
    import msm_pkg::*;
#(
    parameter int WIDTH = FIELD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mod_mul_state_t   state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] step_acc;

    mod_mul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .a_i   (a_q),
        .p_i   (p_q),
        .bit_i (b_q[idx_q]),
        .acc_o (step_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        res_d   = res_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    p_d     = modulus;
                    acc_d   = '0;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                if (idx_q == '0) begin
                    res_d   = step_acc;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input-to-output path.
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = res_q;

endmodule

// File: tb/tb_mod_mul_iter.sv
// Scoreboard bench for mod_mul_iter at WIDTH=8 and WIDTH=256 (BN254).
// Expected values come from plain wide-integer (a*b)%p arithmetic.
module tb_mod_mul_iter;
    import msm_pkg::*;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp8_t;

    typedef struct {
        logic [255:0] res;
        int           cyc;
    } exp256_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       rst8 = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [7:0] p8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] result8;

    logic         rst256 = 1'b1;
    logic         start256 = 1'b0;
    logic [255:0] a256 = '0;
    logic [255:0] b256 = '0;
    logic [255:0] p256 = '0;
    logic         busy256;
    logic         done256;
    logic [255:0] result256;

    exp8_t   q8[$];
    exp256_t q256[$];

    mod_mul_iter #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst8),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .modulus (p8),
        .busy    (busy8),
        .done    (done8),
        .result  (result8)
    );

    mod_mul_iter #(.WIDTH(256)) dut256 (
        .clk     (clk),
        .rst     (rst256),
        .start   (start256),
        .a       (a256),
        .b       (b256),
        .modulus (p256),
        .busy    (busy256),
        .done    (done256),
        .result  (result256)
    );

    function automatic logic [7:0] mm8(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] m);
        int unsigned prod;
        prod = int'(x) * int'(y);
        return 8'(prod % int'(m));
    endfunction

    function automatic logic [255:0] mm256(input logic [255:0] x,
                                           input logic [255:0] y,
                                           input logic [255:0] m);
        logic [511:0] prod;
        prod = {256'b0, x} * {256'b0, y};
        return 256'(prod % {256'b0, m});
    endfunction

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done with empty scoreboard");
            end else begin
                exp8_t e;
                e = q8.pop_front();
                check("result8", 256'(result8), 256'(e.res));
                check("latency8", 256'(cyc), 256'(e.cyc));
            end
        end
        if (done256) begin
            if (q256.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done256_unexpected: got done with empty scoreboard");
            end else begin
                exp256_t e;
                e = q256.pop_front();
                check("result256", result256, e.res);
                check("latency256", 256'(cyc), 256'(e.cyc));
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy8) check("idle8_timeout", 256'(busy8), 256'(0));
    endtask

    task automatic wait_idle256();
        int n = 0;
        @(negedge clk);
        while (busy256 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy256) check("idle256_timeout", 256'(busy256), 256'(0));
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q256.size() != 0) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q8.size() != 0 || q256.size() != 0)
            check("drain_timeout", 256'(q8.size() + q256.size()), 256'(0));
    endtask

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic [7:0] tp);
        wait_idle8();
        a8 = ta;
        b8 = tb_;
        p8 = tp;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        q8.push_back('{mm8(ta, tb_, tp), cyc + 8});
    endtask

    task automatic issue256(input logic [255:0] ta, input logic [255:0] tb_);
        wait_idle256();
        a256 = ta;
        b256 = tb_;
        p256 = BN254_P;
        start256 = 1'b1;
        @(posedge clk);
        #1;
        start256 = 1'b0;
        q256.push_back('{mm256(ta, tb_, BN254_P), cyc + 256});
    endtask

    function automatic logic [255:0] rand_below_p();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r % BN254_P;
    endfunction

    initial begin
        int prev;
        #12;
        check("rst_busy8", 256'(busy8), 256'(0));
        check("rst_done8", 256'(done8), 256'(0));
        check("rst_result8", 256'(result8), 256'(0));
        check("rst_busy256", 256'(busy256), 256'(0));
        @(negedge clk);
        rst8 = 1'b0;
        rst256 = 1'b0;

        // Basic operation, busy timing and result hold.
        wait_idle8();
        check("busy8_pre", 256'(busy8), 256'(0));
        issue8(8'd200, 8'd150, 8'd251);
        check("busy8_post_e0", 256'(busy8), 256'(1));
        drain();
        repeat (3) @(negedge clk);
        check("result8_hold", 256'(result8), 256'(131));
        check("busy8_idle", 256'(busy8), 256'(0));

        issue8(8'd0, 8'd123, 8'd251);
        issue8(8'd1, 8'd250, 8'd251);
        issue8(8'd250, 8'd250, 8'd251);
        drain();

        // Start held high: back-to-back every WIDTH+2 cycles.
        wait_idle8();
        a8 = 8'd17;
        b8 = 8'd33;
        p8 = 8'd251;
        start8 = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_idle8();
            @(posedge clk);
            #1;
            q8.push_back('{8'd59, cyc + 8});
            if (k > 0) check("b2b_period", 256'(cyc - prev), 256'(10));
            prev = cyc;
        end
        start8 = 1'b0;
        drain();

        // Asynchronous reset mid-RUN.
        issue8(8'd250, 8'd250, 8'd251);
        repeat (4) @(posedge clk);
        #2;
        rst8 = 1'b1;
        #1;
        check("abort_busy8", 256'(busy8), 256'(0));
        check("abort_done8", 256'(done8), 256'(0));
        check("abort_result8", 256'(result8), 256'(0));
        q8.delete();
        #1;
        rst8 = 1'b0;
        issue8(8'd250, 8'd250, 8'd251);
        drain();

        // Inputs changed after acceptance must not affect the operation.
        issue8(8'd200, 8'd150, 8'd251);
        @(posedge clk);
        #1;
        a8 = 8'd5;
        b8 = 8'd7;
        p8 = 8'd13;
        drain();

        for (int k = 0; k < 20; k++) begin
            issue8(8'($urandom_range(0, 250)), 8'($urandom_range(0, 250)), 8'd251);
        end
        drain();

        // BN254 field.
        issue256(BN254_P - 256'd1, BN254_P - 256'd1);
        drain();
        check("bn254_m1sq", result256, 256'd1);
        for (int k = 0; k < 50; k++) begin
            issue256(rand_below_p(), rand_below_p());
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
